// File: rtl/lap_record_buffer_pkg.sv
// Shared types and lap-record packing for the lap record buffer.
package lap_record_buffer_pkg;

  typedef enum logic [1:0] {StEmpty, StFollow, StBrowse} lap_state_t;

  localparam int LAP_DATA_W = 28;
  localparam int HOUR_W     = 5;
  localparam int MIN_W      = 6;
  localparam int SEC_W      = 6;
  localparam int CENTI_W    = 7;
  localparam int SPARE_W    = LAP_DATA_W - (HOUR_W + MIN_W + SEC_W + CENTI_W);

  // Spare MSBs are always zero-filled.
  function automatic logic [LAP_DATA_W-1:0] lap_pack(input logic [HOUR_W-1:0]  hour,
                                                     input logic [MIN_W-1:0]   min,
                                                     input logic [SEC_W-1:0]   sec,
                                                     input logic [CENTI_W-1:0] centi);
    return {{SPARE_W{1'b0}}, hour, min, sec, centi};
  endfunction

endpackage

// File: rtl/lap_record_buffer_ram.sv
// Lap record storage: synchronous write, registered read (read-before-write).
module lap_record_buffer_ram #(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 30,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the read register is reset; array contents persist.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lap_record_buffer.sv
// Ring buffer of stopwatch lap records with full policy, occupancy and a
// browse cursor that either follows the newest lap or steps through stored laps.
module lap_record_buffer
  import lap_record_buffer_pkg::*;
#(
  parameter int DATA_W    = LAP_DATA_W,
  parameter int DEPTH     = 30,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter bit OVERWRITE = 1'b1
) (
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iClear,
  input  logic              iLapWe,
  input  logic [DATA_W-1:0] iLapData,
  input  logic              iBrowseNext,
  input  logic              iBrowsePrev,
  input  logic              iBrowseLatest,
  output logic [DATA_W-1:0] oRData,
  output logic              oRValid,
  output logic [ADDR_W-1:0] oRIdx,
  output logic [CNT_W-1:0]  oCount,
  output logic              oFull,
  output logic              oEmpty,
  output logic              oDrop,
  output logic              oOvr
);

  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0]  DepthC   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  OneC     = CNT_W'(1);
  localparam logic [ADDR_W-1:0] OneA     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [SUM_W-1:0]  DepthS   = SUM_W'(DEPTH);

  lap_state_t        r_state;
  logic [ADDR_W-1:0] r_head, r_cursor, r_ridx;
  logic [CNT_W-1:0]  r_count;
  logic              r_drop, r_ovr, r_rvalid;

  lap_state_t        w_state_wr, w_state_n;
  logic [ADDR_W-1:0] w_head_n, w_cur_wr, w_cursor_n, w_last, w_raddr;
  logic [CNT_W-1:0]  w_count_n;
  logic [SUM_W-1:0]  w_head_x, w_old_x, w_sum_x;
  logic              w_full, w_acc, w_ovr, w_drop, w_we;

  assign w_full    = (r_count == DepthC);
  assign w_acc     = iLapWe & (~w_full | OVERWRITE);
  assign w_ovr     = iLapWe & w_full & OVERWRITE;
  assign w_drop    = iLapWe & w_full & ~OVERWRITE;
  assign w_we      = w_acc & ~iClear;
  assign w_head_n  = !w_acc ? r_head : (r_head == LastAddr) ? '0 : r_head + OneA;
  assign w_count_n = (w_acc && !w_full) ? r_count + OneC : r_count;
  assign w_last    = ADDR_W'(w_count_n - OneC);

  // Cursor: apply the write's effect first, then browse against post-write occupancy.
  always_comb begin
    w_state_wr = r_state;
    w_cur_wr   = r_cursor;
    case (r_state)
      StEmpty: begin
        if (w_acc) begin
          w_state_wr = StFollow;
          w_cur_wr   = '0;
        end
      end
      StFollow: if (w_acc) w_cur_wr = w_last;
      StBrowse: if (w_ovr && r_cursor != '0) w_cur_wr = r_cursor - OneA;
      default:  w_state_wr = StEmpty;
    endcase

    w_state_n  = w_state_wr;
    w_cursor_n = w_cur_wr;
    if (w_state_wr != StEmpty) begin
      if (iBrowseLatest) begin
        w_state_n  = StFollow;
        w_cursor_n = w_last;
      end else if (iBrowseNext ^ iBrowsePrev) begin
        w_state_n = StBrowse;
        if (iBrowseNext) begin
          w_cursor_n = (w_cur_wr == w_last) ? '0 : w_cur_wr + OneA;
        end else begin
          w_cursor_n = (w_cur_wr == '0) ? w_last : w_cur_wr - OneA;
        end
      end
    end
  end

  // Physical slot of the cursor: (oldest + cursor) mod DEPTH, no power-of-2 assumption.
  always_comb begin
    w_head_x = SUM_W'(r_head);
    w_old_x  = (w_head_x >= SUM_W'(r_count)) ? w_head_x - SUM_W'(r_count)
                                             : w_head_x + DepthS - SUM_W'(r_count);
    w_sum_x  = w_old_x + SUM_W'(r_cursor);
    if (w_sum_x >= DepthS) begin
      w_sum_x = w_sum_x - DepthS;
    end
    w_raddr = ADDR_W'(w_sum_x);
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state  <= StEmpty;
      r_head   <= '0;
      r_count  <= '0;
      r_cursor <= '0;
      r_drop   <= 1'b0;
      r_ovr    <= 1'b0;
      r_ridx   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_ridx   <= r_cursor;
      r_rvalid <= (r_state != StEmpty);
      if (iClear) begin
        r_state  <= StEmpty;
        r_head   <= '0;
        r_count  <= '0;
        r_cursor <= '0;
        r_drop   <= 1'b0;
        r_ovr    <= 1'b0;
      end else begin
        r_state  <= w_state_n;
        r_head   <= w_head_n;
        r_count  <= w_count_n;
        r_cursor <= w_cursor_n;
        r_drop   <= w_drop;
        r_ovr    <= w_ovr;
      end
    end
  end

  lap_record_buffer_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk  (iClk),
    .i_rst_n(iRstn),
    .i_we   (w_we),
    .i_waddr(r_head),
    .i_wdata(iLapData),
    .i_raddr(w_raddr),
    .o_rdata(oRData)
  );

  assign oRValid = r_rvalid;
  assign oRIdx   = r_ridx;
  assign oCount  = r_count;
  assign oFull   = w_full;
  assign oEmpty  = (r_count == '0);
  assign oDrop   = r_drop;
  assign oOvr    = r_ovr;

endmodule

// File: tb/tb_lap_record_buffer.sv
// Bench for lap_record_buffer: three instances (depth 4 overwrite, depth 4 drop,
// depth 30 overwrite) share one stimulus stream and are checked against list models.
module tb_lap_record_buffer;
  import lap_record_buffer_pkg::*;

  localparam int NI = 3;

  logic        iClk = 1'b0;
  logic        iRstn, iClear, iLapWe, iNext, iPrev, iLatest;
  logic [27:0] iLapData;

  logic [27:0] rd0, rd1, rd2;
  logic [1:0]  ri0, ri1;
  logic [4:0]  ri2;
  logic [2:0]  cnt0, cnt1;
  logic [4:0]  cnt2;
  logic        rv0, rv1, rv2, fu0, fu1, fu2, em0, em1, em2;
  logic        dr0, dr1, dr2, ov0, ov1, ov2;

  always #5 iClk = ~iClk;

  lap_record_buffer #(.DEPTH(4), .OVERWRITE(1'b1)) u_d4o (
    .iClk(iClk), .iRstn(iRstn), .iClear(iClear), .iLapWe(iLapWe), .iLapData(iLapData),
    .iBrowseNext(iNext), .iBrowsePrev(iPrev), .iBrowseLatest(iLatest),
    .oRData(rd0), .oRValid(rv0), .oRIdx(ri0), .oCount(cnt0), .oFull(fu0), .oEmpty(em0),
    .oDrop(dr0), .oOvr(ov0));

  lap_record_buffer #(.DEPTH(4), .OVERWRITE(1'b0)) u_d4d (
    .iClk(iClk), .iRstn(iRstn), .iClear(iClear), .iLapWe(iLapWe), .iLapData(iLapData),
    .iBrowseNext(iNext), .iBrowsePrev(iPrev), .iBrowseLatest(iLatest),
    .oRData(rd1), .oRValid(rv1), .oRIdx(ri1), .oCount(cnt1), .oFull(fu1), .oEmpty(em1),
    .oDrop(dr1), .oOvr(ov1));

  lap_record_buffer #(.DEPTH(30), .OVERWRITE(1'b1)) u_d30 (
    .iClk(iClk), .iRstn(iRstn), .iClear(iClear), .iLapWe(iLapWe), .iLapData(iLapData),
    .iBrowseNext(iNext), .iBrowsePrev(iPrev), .iBrowseLatest(iLatest),
    .oRData(rd2), .oRValid(rv2), .oRIdx(ri2), .oCount(cnt2), .oFull(fu2), .oEmpty(em2),
    .oDrop(dr2), .oOvr(ov2));

  logic [31:0] a_rd[NI], a_rv[NI], a_ri[NI], a_cnt[NI], a_fu[NI], a_em[NI], a_dr[NI], a_ov[NI];
  assign a_rd[0] = 32'(rd0);   assign a_rd[1] = 32'(rd1);   assign a_rd[2] = 32'(rd2);
  assign a_rv[0] = 32'(rv0);   assign a_rv[1] = 32'(rv1);   assign a_rv[2] = 32'(rv2);
  assign a_ri[0] = 32'(ri0);   assign a_ri[1] = 32'(ri1);   assign a_ri[2] = 32'(ri2);
  assign a_cnt[0] = 32'(cnt0); assign a_cnt[1] = 32'(cnt1); assign a_cnt[2] = 32'(cnt2);
  assign a_fu[0] = 32'(fu0);   assign a_fu[1] = 32'(fu1);   assign a_fu[2] = 32'(fu2);
  assign a_em[0] = 32'(em0);   assign a_em[1] = 32'(em1);   assign a_em[2] = 32'(em2);
  assign a_dr[0] = 32'(dr0);   assign a_dr[1] = 32'(dr1);   assign a_dr[2] = 32'(dr2);
  assign a_ov[0] = 32'(ov0);   assign a_ov[1] = 32'(ov1);   assign a_ov[2] = 32'(ov2);

  // Model: list[0] is the oldest record; overwrite shifts the list down by one.
  int          depth_of[NI];
  bit          ovr_of[NI];
  logic [27:0] m_list[NI][32];
  int          m_cnt[NI], m_cur[NI], m_st[NI];  // m_st: 0 empty, 1 follow, 2 browse
  bit          m_drop[NI], m_ovr[NI], e_val[NI];
  logic [27:0] e_rd[NI];
  int          e_idx[NI];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", name, k, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = 0; m_cur[k] = 0; m_st[k] = 0; m_drop[k] = 0; m_ovr[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k, input bit we, input logic [27:0] d,
                                     input bit n, input bit p, input bit l, input bit c);
    bit acc;
    e_rd[k]  = m_list[k][m_cur[k]];
    e_idx[k] = m_cur[k];
    e_val[k] = (m_st[k] != 0);
    m_drop[k] = 0;
    m_ovr[k]  = 0;
    if (c) begin
      m_cnt[k] = 0; m_cur[k] = 0; m_st[k] = 0;
      return;
    end
    acc = 0;
    if (we) begin
      if (m_cnt[k] < depth_of[k]) begin
        m_list[k][m_cnt[k]] = d; m_cnt[k]++; acc = 1;
      end else if (ovr_of[k]) begin
        for (int j = 0; j < depth_of[k] - 1; j++) m_list[k][j] = m_list[k][j+1];
        m_list[k][depth_of[k]-1] = d; m_ovr[k] = 1; acc = 1;
      end else begin
        m_drop[k] = 1;
      end
    end
    if (m_st[k] == 0) begin
      if (acc) begin m_st[k] = 1; m_cur[k] = 0; end
    end else if (m_st[k] == 1) begin
      if (acc) m_cur[k] = m_cnt[k] - 1;
    end else if (m_ovr[k] && m_cur[k] > 0) begin
      m_cur[k]--;
    end
    if (m_st[k] != 0) begin
      if (l) begin
        m_st[k] = 1; m_cur[k] = m_cnt[k] - 1;
      end else if (n != p) begin
        m_st[k] = 2;
        m_cur[k] = n ? (m_cur[k] + 1) % m_cnt[k] : (m_cur[k] + m_cnt[k] - 1) % m_cnt[k];
      end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk("count", k, a_cnt[k], 32'(m_cnt[k]));
      chk("full",  k, a_fu[k],  32'(m_cnt[k] == depth_of[k]));
      chk("empty", k, a_em[k],  32'(m_cnt[k] == 0));
      chk("drop",  k, a_dr[k],  32'(m_drop[k]));
      chk("ovr",   k, a_ov[k],  32'(m_ovr[k]));
      chk("valid", k, a_rv[k],  32'(e_val[k]));
      chk("idx",   k, a_ri[k],  32'(e_idx[k]));
      if (e_val[k]) chk("rdata", k, a_rd[k], 32'(e_rd[k]));
    end
  endtask

  task automatic step(input bit we, input logic [27:0] d, input bit n, input bit p,
                      input bit l, input bit c);
    iLapWe = we; iLapData = d; iNext = n; iPrev = p; iLatest = l; iClear = c;
    for (int k = 0; k < NI; k++) model_step(k, we, d, n, p, l, c);
    @(posedge iClk);
    #1;
    compare_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_rdata"}, k, a_rd[k], 0);  chk({tag, "_valid"}, k, a_rv[k], 0);
      chk({tag, "_idx"},   k, a_ri[k], 0);  chk({tag, "_count"}, k, a_cnt[k], 0);
      chk({tag, "_empty"}, k, a_em[k], 1);  chk({tag, "_full"},  k, a_fu[k], 0);
      chk({tag, "_drop"},  k, a_dr[k], 0);  chk({tag, "_ovr"},   k, a_ov[k], 0);
    end
  endtask

  function automatic logic [27:0] rec(input int i);
    return lap_pack(5'd0, 6'd0, 6'(i), 7'(i));
  endfunction

  typedef struct {
    bit we; logic [27:0] d; bit n; bit p; bit l; bit c;
    int cnt; bit val; int idx; logic [27:0] rd; bit ovr;
  } vec_t;

  localparam logic [27:0] LA = 28'h0A0A0A1, LB = 28'h0B0B0B2, LC = 28'h0C0C0C3;
  localparam logic [27:0] LD = 28'h0D0D0D4, LE = 28'h0E0E0E5, LF = 28'h0F0F0F6;
  localparam logic [27:0] LG = 28'h0123456;

  vec_t tv[27];

  initial begin
    depth_of = '{4, 4, 30};
    ovr_of   = '{1'b1, 1'b0, 1'b1};
    // Expectations for the depth-4 overwrite instance (rd fields lag one edge).
    tv[0]  = '{1, LA, 0, 0, 0, 0, 1, 0, 0, 0,  0};
    tv[1]  = '{1, LB, 0, 0, 0, 0, 2, 1, 0, LA, 0};
    tv[2]  = '{1, LC, 0, 0, 0, 0, 3, 1, 1, LB, 0};
    tv[3]  = '{0, 0,  0, 0, 0, 0, 3, 1, 2, LC, 0};
    tv[4]  = '{1, LD, 0, 0, 0, 0, 4, 1, 2, LC, 0};
    tv[5]  = '{1, LE, 0, 0, 0, 0, 4, 1, 3, LD, 1};
    tv[6]  = '{0, 0,  0, 1, 0, 0, 4, 1, 3, LE, 0};
    tv[7]  = '{0, 0,  0, 1, 0, 0, 4, 1, 2, LD, 0};
    tv[8]  = '{0, 0,  0, 1, 0, 0, 4, 1, 1, LC, 0};
    tv[9]  = '{0, 0,  0, 1, 0, 0, 4, 1, 0, LB, 0};
    tv[10] = '{0, 0,  0, 0, 0, 0, 4, 1, 3, LE, 0};
    tv[11] = '{0, 0,  0, 0, 1, 0, 4, 1, 3, LE, 0};
    tv[12] = '{0, 0,  0, 0, 0, 1, 0, 1, 3, LE, 0};
    tv[13] = '{1, LA, 0, 0, 0, 0, 1, 0, 0, 0,  0};
    tv[14] = '{1, LB, 0, 0, 0, 0, 2, 1, 0, LA, 0};
    tv[15] = '{1, LC, 0, 0, 0, 0, 3, 1, 1, LB, 0};
    tv[16] = '{1, LD, 0, 0, 0, 0, 4, 1, 2, LC, 0};
    tv[17] = '{0, 0,  0, 1, 0, 0, 4, 1, 3, LD, 0};
    tv[18] = '{0, 0,  0, 1, 0, 0, 4, 1, 2, LC, 0};
    tv[19] = '{1, LF, 0, 0, 0, 0, 4, 1, 1, LB, 1};
    tv[20] = '{0, 0,  0, 0, 0, 0, 4, 1, 0, LB, 0};
    tv[21] = '{0, 0,  0, 0, 1, 0, 4, 1, 0, LB, 0};
    tv[22] = '{0, 0,  0, 0, 0, 0, 4, 1, 3, LF, 0};
    tv[23] = '{1, LG, 1, 0, 0, 1, 0, 1, 3, LF, 0};
    tv[24] = '{0, 0,  1, 0, 0, 0, 0, 0, 0, 0,  0};
    tv[25] = '{0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  0};
    tv[26] = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0};

    iRstn = 1'b1; iClear = 0; iLapWe = 0; iLapData = '0; iNext = 0; iPrev = 0; iLatest = 0;
    model_reset();
    #2 iRstn = 1'b0;
    #1 chk_reset_vals("reset");
    @(negedge iClk);
    iRstn = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].we, tv[i].d, tv[i].n, tv[i].p, tv[i].l, tv[i].c);
      chk("tv_count", i, a_cnt[0], 32'(tv[i].cnt));
      chk("tv_valid", i, a_rv[0],  32'(tv[i].val));
      chk("tv_idx",   i, a_ri[0],  32'(tv[i].idx));
      chk("tv_ovr",   i, a_ov[0],  32'(tv[i].ovr));
      if (tv[i].val) chk("tv_rdata", i, a_rd[0], 32'(tv[i].rd));
    end

    // Depth-30 wrap: 31 laps push out record 1.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 31; i++) step(1, rec(i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("d30_count", 2, a_cnt[2], 30);
    chk("d30_idx",   2, a_ri[2],  29);
    chk("d30_newest", 2, a_rd[2], 32'(rec(31)));
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("d30_wrap_idx", 2, a_ri[2], 0);
    chk("d30_oldest",   2, a_rd[2], 32'(rec(2)));

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1, 28'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset in the middle of browsing.
    step(0, 0, 0, 0, 0, 1);
    step(1, LA, 0, 0, 0, 0);
    step(1, LB, 0, 0, 0, 0);
    step(1, LC, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    #2 iRstn = 1'b0;
    #1 chk_reset_vals("async");
    model_reset();
    iLapWe = 0; iNext = 0; iPrev = 0; iLatest = 0; iClear = 0;
    @(negedge iClk);
    iRstn = 1'b1;
    step(1, LD, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_record_buffer.md
Name: lap_record_buffer

Overview:
Parametrised ring buffer for stopwatch lap records. It replaces the fixed 30 x 28-bit lap RAM with:
- configurable depth and width;
- a full-policy mode (overwrite oldest or drop newest);
- occupancy tracking;
- a browse cursor FSM that either follows the newest lap or lets the user step through stored laps.

It sits between the stopwatch core (lap capture) and the display mux (lap recall).

Parameters:
DATA_W, 28, record width; default packs {Hour, Min, Sec, Centisec}.
DEPTH, 30, number of records; any value >= 2, need not be a power of 2.
ADDR_W, $clog2(DEPTH), pointer/index width.
CNT_W, $clog2(DEPTH+1), occupancy width.
OVERWRITE, 1, full policy: 1 = new lap overwrites oldest; 0 = new lap dropped.

Ports:
iClk  in  1  clock.
iRstn  in  1  asynchronous active-low reset.
iClear  in  1  discard all records (synchronous).
iLapWe  in  1  write iLapData as newest record this cycle.
iLapData  in  DATA_W  lap record.
iBrowseNext  in  1  cursor toward newer record.
iBrowsePrev  in  1  cursor toward older record.
iBrowseLatest  in  1  return cursor to newest, re-enter follow mode.
oRData  out  DATA_W  record under cursor (registered).
oRValid  out  1  oRData is a stored record.
oRIdx  out  ADDR_W  cursor index, 0 = oldest stored.
oCount  out  CNT_W  records stored, 0..DEPTH.
oFull  out  1  oCount == DEPTH.
oEmpty  out  1  oCount == 0.
oDrop  out  1  one-cycle pulse: write rejected (full, OVERWRITE=0).
oOvr  out  1  one-cycle pulse: oldest record overwritten.

Behaviour:
- Reset (async, iRstn=0):
  - head pointer = 0, oCount = 0, cursor = 0, state EMPTY.
  - oRData = 0, oRValid = 0, oRIdx = 0, oEmpty = 1, oFull = 0, oDrop = 0, oOvr = 0.
  - Array contents are not reset.
- Storage: head = next write slot; oldest = (head - oCount) mod DEPTH. All pointer increments wrap explicitly at DEPTH-1 -> 0, not at 2^ADDR_W.
- Write, iLapWe=1:
  - Not full: mem[head] <= data; head++; oCount++.
  - Full, OVERWRITE=1: mem[head] <= data; head++; oCount unchanged; oOvr pulses.
  - Full, OVERWRITE=0: no write; oDrop pulses.
- FSM states: EMPTY, FOLLOW, BROWSE.
  - EMPTY -> FOLLOW on an accepted write; cursor = 0.
  - FOLLOW: after each accepted write, cursor = post-write oCount-1. Next/Prev -> BROWSE.
  - BROWSE: the cursor tracks a record, not a position.
    - If an overwrite shifts the oldest record, cursor = max(cursor-1, 0).
    - iBrowseLatest -> FOLLOW with cursor = oCount-1.
  - iClear from any state -> EMPTY; head, oCount, cursor = 0. iClear has priority over a same-cycle write and browse.
- Cursor movement:
  - Next: cursor+1, wrapping from oCount-1 to 0.
  - Prev: cursor-1, wrapping from 0 to oCount-1.
  - Priority: Latest > (Next xor Prev). Next and Prev together with no Latest: no move.
  - Browse inputs in EMPTY are ignored.
- Write + browse in the same cycle: the write is applied first, then the cursor rule evaluates against post-write oCount/oldest.
- Read latency:
  - State updates at edge N; oRData = mem[(oldest+cursor) mod DEPTH] and oRIdx = cursor are registered at edge N+1.
  - A lap written at edge N is visible in FOLLOW at edge N+1.
  - oRValid = (state != EMPTY), registered with the same one-cycle latency.
- oCount, oFull and oEmpty are registered and update at edge N, with no extra cycle.

Decomposition:
- stopwatch_pkg holds:
  - the lap_state_t enum {EMPTY, FOLLOW, BROWSE};
  - LAP_DATA_W = 28;
  - field widths for packing (HOUR_W 5, MIN_W 6, SEC_W 6, CENTI_W 7, summing to 24 plus 4 spare MSBs, zero-filled).
- Sub-module lap_ram: parametrised DATA_W x DEPTH array with synchronous write and synchronous read. Its read port feeds oRData directly, so the 1-cycle latency lives there.

Test Plan (DEPTH=4 unless noted):
- Reset, then write A,B,C on consecutive cycles -> oCount 1,2,3; oRData B one cycle after B's write edge; oRIdx=2 after C.
- Write A..E with OVERWRITE=1 -> oFull=1, oOvr pulse on E; Prev x4 from FOLLOW shows D,C,B,E (wraps); oRIdx 2,1,0,3.
- Same sequence with OVERWRITE=0 -> E dropped, oDrop single pulse, oCount=4, newest remains D.
- BROWSE on B (idx 1) while full with OVERWRITE=1, then write F -> oRIdx becomes 0, oRData still B; iBrowseLatest -> oRData F, state FOLLOW.
- Same-cycle iClear + iLapWe + iBrowseNext -> oCount=0, oEmpty=1, oRValid=0 next cycle; Next/Prev afterwards have no effect.
- DEPTH=30: 31 writes with OVERWRITE=1 -> head wraps 29->0, oldest = record #2, no index reaches 30/31.
- Assert iRstn low mid-BROWSE -> all outputs at reset values asynchronously, before the next clock edge.
